// File: rtl/wash_timer_unit_pkg.sv
// Shared wash_defs constants and helpers for the wash timer unit, its controller and bench.
package wash_timer_unit_pkg;

  // Default timebase and duration constants
  localparam int unsigned DEF_TICK_DIV    = 100;
  localparam int unsigned DEF_LEVEL_MAX   = 16;
  localparam int unsigned DEF_CYCLE_TICKS = 200;
  localparam int unsigned DEF_SPIN_TICKS  = 100;

  // Level estimator action for one tick
  typedef enum logic [1:0] {
    LVL_HOLD = 2'd0,
    LVL_UP   = 2'd1,
    LVL_DOWN = 2'd2
  } lvl_op_e;

  // Fill alone raises the level, drain alone lowers it, otherwise hold
  function automatic lvl_op_e level_op(input logic fill, input logic drain);
    lvl_op_e op;
    case ({fill, drain})
      2'b10:   op = LVL_UP;
      2'b01:   op = LVL_DOWN;
      default: op = LVL_HOLD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/wash_tick_timer.sv
// Saturating tick counter, cleared whenever the enable is low.
module wash_tick_timer #(
  parameter int unsigned LIMIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic tick,
  output logic expired
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_count;

  // Clear has priority over the tick; the counter sticks at LIMIT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (!en) begin
      r_count <= '0;
    end else if (tick && (r_count != CW'(LIMIT))) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign expired = (r_count == CW'(LIMIT));

endmodule

// File: rtl/wash_timer_unit.sv
// Timebase and sensing front-end: prescaler, open-loop level estimator, wash and spin timers.
module wash_timer_unit
  import wash_timer_unit_pkg::*;
#(
  parameter int unsigned TICK_DIV    = DEF_TICK_DIV,
  parameter int unsigned LEVEL_MAX   = DEF_LEVEL_MAX,
  parameter int unsigned CYCLE_TICKS = DEF_CYCLE_TICKS,
  parameter int unsigned SPIN_TICKS  = DEF_SPIN_TICKS
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               motor_on,
  input  logic                               fill_value_on,
  input  logic                               drain_value_on,
  output logic                               filled,
  output logic                               drained,
  output logic                               cycle_timeout,
  output logic                               spin_timeout,
  output logic [$clog2(LEVEL_MAX + 1)-1:0]   water_level
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned LW = $clog2(LEVEL_MAX + 1);

  logic [PW-1:0] r_presc;
  logic [LW-1:0] r_level;
  logic [LW-1:0] w_level_nxt;
  logic          w_tick;
  logic          w_spin_en;
  lvl_op_e       w_op;

  // Free-running prescaler, one tick per TICK_DIV clocks
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  assign w_tick = (r_presc == PW'(TICK_DIV - 1));

  // Next level: saturating step in the direction the valves imply
  always_comb begin
    w_level_nxt = r_level;
    w_op        = level_op(fill_value_on, drain_value_on);
    if (w_tick) begin
      case (w_op)
        LVL_UP:   if (r_level != LW'(LEVEL_MAX)) w_level_nxt = r_level + LW'(1);
        LVL_DOWN: if (r_level != '0)             w_level_nxt = r_level - LW'(1);
        default:  w_level_nxt = r_level;
      endcase
    end
  end

  // Level register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_level <= '0;
    end else begin
      r_level <= w_level_nxt;
    end
  end

  assign filled      = (r_level == LW'(LEVEL_MAX));
  assign drained     = (r_level == '0);
  assign water_level = r_level;

  // Spin is the drain valve running on an already empty drum
  assign w_spin_en = drain_value_on & drained & ~fill_value_on;

  wash_tick_timer #(.LIMIT(CYCLE_TICKS)) u_cycle_timer (
    .clk     (clk),
    .reset   (reset),
    .en      (motor_on),
    .tick    (w_tick),
    .expired (cycle_timeout)
  );

  wash_tick_timer #(.LIMIT(SPIN_TICKS)) u_spin_timer (
    .clk     (clk),
    .reset   (reset),
    .en      (w_spin_en),
    .tick    (w_tick),
    .expired (spin_timeout)
  );

endmodule

// File: tb/tb_wash_timer_unit.sv
// Vector table plus scoreboard queue bench for wash_timer_unit at small parameters.
module tb_wash_timer_unit;

  localparam int unsigned TICK_DIV    = 4;
  localparam int unsigned LEVEL_MAX   = 3;
  localparam int unsigned CYCLE_TICKS = 5;
  localparam int unsigned SPIN_TICKS  = 2;
  localparam int unsigned NVEC        = 24;

  typedef struct packed {
    logic [1:0] lvl;
    logic       filled;
    logic       drained;
    logic       cto;
    logic       sto;
  } obs_t;

  typedef struct {
    logic motor;
    logic fill;
    logic drain;
    int   ncyc;
    obs_t exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       motor_on, fill_value_on, drain_value_on;
  logic       filled, drained, cycle_timeout, spin_timeout;
  logic [1:0] water_level;

  int   n_checks = 0;
  int   n_fail   = 0;
  obs_t sb_q[$];
  vec_t vecs[NVEC];

  always #5 clk = ~clk;

  wash_timer_unit #(
    .TICK_DIV(TICK_DIV), .LEVEL_MAX(LEVEL_MAX),
    .CYCLE_TICKS(CYCLE_TICKS), .SPIN_TICKS(SPIN_TICKS)
  ) dut (
    .clk(clk), .reset(reset), .motor_on(motor_on), .fill_value_on(fill_value_on),
    .drain_value_on(drain_value_on), .filled(filled), .drained(drained),
    .cycle_timeout(cycle_timeout), .spin_timeout(spin_timeout), .water_level(water_level)
  );

  function automatic obs_t ob(int lvl, bit cto, bit sto);
    obs_t o;
    o.lvl     = 2'(lvl);
    o.filled  = (lvl == int'(LEVEL_MAX));
    o.drained = (lvl == 0);
    o.cto     = cto;
    o.sto     = sto;
    return o;
  endfunction

  function automatic vec_t mk(bit m, bit f, bit d, int n, obs_t e);
    vec_t v;
    v.motor = m; v.fill = f; v.drain = d; v.ncyc = n; v.exp = e;
    return v;
  endfunction

  // Pop the oldest expectation and compare it with what the DUT shows now
  task automatic check(input string name);
    obs_t act, exp;
    act = {water_level, filled, drained, cycle_timeout, spin_timeout};
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, actual %b", name, act);
    end else begin
      exp = sb_q.pop_front();
      if (act !== exp) begin
        n_fail++;
        $display("FAIL %s: actual lvl/fil/drn/cto/sto=%b required %b", name, act, exp);
      end
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %b required %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  initial begin
    int cnt;
    // Edge numbers below count rising edges since reset release
    vecs[0]  = mk(0, 1, 0,  3, ob(0, 0, 0)); // edge 3
    vecs[1]  = mk(0, 1, 0,  1, ob(1, 0, 0)); // edge 4
    vecs[2]  = mk(0, 1, 0,  4, ob(2, 0, 0)); // edge 8
    vecs[3]  = mk(0, 1, 0,  4, ob(3, 0, 0)); // edge 12, filled
    vecs[4]  = mk(0, 1, 0, 28, ob(3, 0, 0)); // edge 40, saturated
    vecs[5]  = mk(1, 0, 0, 19, ob(3, 0, 0)); // edge 59, cycle count 4
    vecs[6]  = mk(1, 0, 0,  1, ob(3, 1, 0)); // edge 60, timeout
    vecs[7]  = mk(1, 0, 0,  8, ob(3, 1, 0)); // edge 68, held
    vecs[8]  = mk(0, 0, 0,  1, ob(3, 0, 0)); // edge 69, cleared
    vecs[9]  = mk(1, 0, 0,  7, ob(3, 0, 0)); // edge 76, count 2
    vecs[10] = mk(0, 0, 0,  1, ob(3, 0, 0)); // edge 77, cleared
    vecs[11] = mk(1, 0, 0, 11, ob(3, 0, 0)); // edge 88, would expire without restart
    vecs[12] = mk(1, 0, 0,  7, ob(3, 0, 0)); // edge 95, count 4
    vecs[13] = mk(1, 0, 0,  1, ob(3, 1, 0)); // edge 96, timeout
    vecs[14] = mk(0, 0, 0,  1, ob(3, 0, 0)); // edge 97
    vecs[15] = mk(0, 0, 1,  3, ob(2, 0, 0)); // edge 100
    vecs[16] = mk(0, 0, 1,  8, ob(0, 0, 0)); // edge 108, drained
    vecs[17] = mk(0, 0, 1,  7, ob(0, 0, 0)); // edge 115, spin count 1
    vecs[18] = mk(0, 0, 1,  1, ob(0, 0, 1)); // edge 116, spin timeout
    vecs[19] = mk(0, 0, 1,  6, ob(0, 0, 1)); // edge 122, held
    vecs[20] = mk(0, 1, 1,  1, ob(0, 0, 0)); // edge 123, fill blocks spin
    vecs[21] = mk(0, 1, 1,  8, ob(0, 0, 0)); // edge 131
    vecs[22] = mk(0, 1, 0,  5, ob(2, 0, 0)); // edge 136
    vecs[23] = mk(0, 1, 1,  8, ob(2, 0, 0)); // edge 144, both valves hold level

    // Reset with idle inputs
    reset = 1'b0; motor_on = 1'b0; fill_value_on = 1'b0; drain_value_on = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    sb_q.push_back(ob(0, 0, 0));
    check("reset_state");
    reset = 1'b1;

    // Table-driven vectors, inputs changed on the falling edge
    for (int i = 0; i < int'(NVEC); i++) begin
      motor_on = vecs[i].motor; fill_value_on = vecs[i].fill; drain_value_on = vecs[i].drain;
      sb_q.push_back(vecs[i].exp);
      repeat (vecs[i].ncyc) @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d", i));
    end

    // Closed-loop wash: drop motor as soon as the timeout is seen
    motor_on = 1'b1; fill_value_on = 1'b0; drain_value_on = 1'b0;
    cnt = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); @(negedge clk);
      if (cycle_timeout) begin cnt = i; break; end
    end
    check_int("cycle_timeout_latency", cnt, 20);
    motor_on = 1'b0;
    @(posedge clk); @(negedge clk);
    check_bit("cycle_timeout_width", cycle_timeout, 1'b0);

    // Closed-loop drain then spin from level 2
    drain_value_on = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); @(negedge clk);
      if (spin_timeout) begin cnt = i; break; end
    end
    check_int("spin_timeout_latency", cnt, 15);
    drain_value_on = 1'b0;
    @(posedge clk); @(negedge clk);
    check_bit("spin_timeout_width", spin_timeout, 1'b0);

    // Fill to level 2, then reset asynchronously between edges
    fill_value_on = 1'b1;
    sb_q.push_back(ob(2, 0, 0));
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("refill_before_reset");
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    sb_q.push_back(ob(0, 0, 0));
    check("async_reset_midfill");
    fill_value_on = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
